morse_key_classifier: RTL and testbench

Front-end timing stage directly upstream of the morse decoder. Takes a single raw straight-key line and measures key-down and key-up durations in dot units. Emits one-cycle, mutually exclusive dot_inp / dash_inp / char_space_inp / word_space_inp pulses, which the decoder consumes to produce its 8-bit ASCII sout. Also flags stuck/over-long presses.

---
 rtl/morse_pkg.sv | 35 +++
 rtl/morse_key_sync.sv | 68 ++++++
 rtl/morse_key_classifier.sv | 144 ++++++++++++++
 tb/tb_morse_key_classifier.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the morse key classifier.
// Imported by morse_key_sync and morse_key_classifier.
package morse_pkg;

    localparam int UNIT_W = 8;

    localparam int DEF_UNIT_CYCLES     = 1000;
    localparam int DEF_DASH_UNITS      = 2;
    localparam int DEF_CHAR_GAP_UNITS  = 3;
    localparam int DEF_WORD_GAP_UNITS  = 7;
    localparam int DEF_MAX_PRESS_UNITS = 10;
    localparam int DEF_DEBOUNCE_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        STUCK
    } morse_state_e;

    typedef struct packed {
        logic dot;
        logic dash;
        logic char_space;
        logic word_space;
        logic press_err;
    } morse_pulse_t;

    function automatic logic [UNIT_W-1:0] sat_inc(
        input logic [UNIT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/morse_key_sync.sv
// Key synchronizer, optional debounce (MORSE_CLASSIFIER_DEBOUNCE_EN)
// and edge detector producing key_f, rise and fall.
module morse_key_sync
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_f,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       key_s;
    logic       key_d;

    // Flops reset high so a key held through reset yields no rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    assign key_s = sync_q[1];

`ifdef MORSE_CLASSIFIER_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt;
    logic          key_db;

    always_ff @(posedge clk) begin
        if (!rst) begin
            db_cnt <= '0;
            key_db <= 1'b1;
        end else if (key_s == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            key_db <= key_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign key_f = key_db;
`else
    assign key_f = key_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_d <= 1'b1;
        end else begin
            key_d <= key_f;
        end
    end

    assign rise = key_f & ~key_d;
    assign fall = ~key_f & key_d;

endmodule

// File: rtl/morse_key_classifier.sv
// Straight-key timing front end: classifies presses and gaps into pulses.
// Optional input debounce is enabled by MORSE_CLASSIFIER_DEBOUNCE_EN.
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = DEF_UNIT_CYCLES,
    parameter int DASH_UNITS      = DEF_DASH_UNITS,
    parameter int CHAR_GAP_UNITS  = DEF_CHAR_GAP_UNITS,
    parameter int WORD_GAP_UNITS  = DEF_WORD_GAP_UNITS,
    parameter int MAX_PRESS_UNITS = DEF_MAX_PRESS_UNITS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic dot_inp,
    output logic dash_inp,
    output logic char_space_inp,
    output logic word_space_inp,
    output logic press_err
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);

    localparam logic [UNIT_W-1:0] DASH_U = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] CHAR_U = UNIT_W'(CHAR_GAP_UNITS);
    localparam logic [UNIT_W-1:0] WORD_U = UNIT_W'(WORD_GAP_UNITS);
    localparam logic [UNIT_W-1:0] MAX_U  = UNIT_W'(MAX_PRESS_UNITS);

    logic              key_f;
    logic              rise;
    logic              fall;
    logic              edge_seen;
    logic [PW-1:0]     presc;
    logic              unit_tick;
    logic [UNIT_W-1:0] units;
    logic [UNIT_W-1:0] units_next;
    morse_state_e      state_q;
    morse_state_e      state_d;
    morse_pulse_t      pulse_d;
    morse_pulse_t      pulse_q;

    morse_key_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .key_f (key_f),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_seen = rise | fall;
    assign unit_tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
        end else if (edge_seen || unit_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            units <= '0;
        end else if (edge_seen) begin
            units <= '0;
        end else if (unit_tick) begin
            units <= sat_inc(units);
        end
    end

    // Count including a tick landing in this very cycle, so a press of
    // exactly N units classifies as N units.
    assign units_next = unit_tick ? sat_inc(units) : units;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (units_next >= MAX_U) begin
                    pulse_d.press_err = 1'b1;
                    state_d           = STUCK;
                end else if (fall) begin
                    if (units_next < DASH_U) begin
                        pulse_d.dot = 1'b1;
                    end else begin
                        pulse_d.dash = 1'b1;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS;
                end else if (unit_tick && units_next == WORD_U) begin
                    pulse_d.word_space = 1'b1;
                    state_d            = IDLE;
                end else if (unit_tick && units_next == CHAR_U) begin
                    pulse_d.char_space = 1'b1;
                end
            end
            STUCK: begin
                // Level test: the release may coincide with the error cycle.
                if (rise) begin
                    state_d = PRESS;
                end else if (!key_f) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dot_inp        = pulse_q.dot;
    assign dash_inp       = pulse_q.dash;
    assign char_space_inp = pulse_q.char_space;
    assign word_space_inp = pulse_q.word_space;
    assign press_err      = pulse_q.press_err;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Bench for morse_key_classifier: directed and random key patterns
// checked against an event-list model of the timing rules.
module tb_morse_key_classifier;

    localparam int U     = 4;
    localparam int DEB   = 8;
    localparam int DASH  = 2;
    localparam int CHARG = 3;
    localparam int WORDG = 7;
    localparam int MAXP  = 10;
`ifdef MORSE_CLASSIFIER_DEBOUNCE_EN
    localparam int LAT  = 2 + DEB;
    localparam int MINL = DEB + 2;
`else
    localparam int LAT  = 2;
    localparam int MINL = 1;
`endif
    localparam int TAIL = WORDG * U + LAT + 12;

    localparam int K_DOT  = 0;
    localparam int K_DASH = 1;
    localparam int K_CHAR = 2;
    localparam int K_WORD = 3;
    localparam int K_ERR  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_in = 1'b0;
    logic dot_inp;
    logic dash_inp;
    logic char_space_inp;
    logic word_space_inp;
    logic press_err;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int act_q[$];
    int exp_q[$];
    int segs[$];

    morse_key_classifier #(
        .UNIT_CYCLES    (U),
        .DASH_UNITS     (DASH),
        .CHAR_GAP_UNITS (CHARG),
        .WORD_GAP_UNITS (WORDG),
        .MAX_PRESS_UNITS(MAXP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .dot_inp       (dot_inp),
        .dash_inp      (dash_inp),
        .char_space_inp(char_space_inp),
        .word_space_inp(word_space_inp),
        .press_err     (press_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (dot_inp === 1'b1) act_q.push_back(cyc * 8 + K_DOT);
            if (dash_inp === 1'b1) act_q.push_back(cyc * 8 + K_DASH);
            if (char_space_inp === 1'b1) act_q.push_back(cyc * 8 + K_CHAR);
            if (word_space_inp === 1'b1) act_q.push_back(cyc * 8 + K_WORD);
            if (press_err === 1'b1) act_q.push_back(cyc * 8 + K_ERR);
            vectors++;
            assert ($countones({dot_inp, dash_inp, char_space_inp,
                                word_space_inp, press_err}) <= 1)
            else begin
                miscompares++;
                $error("FAIL onehot cycle %0d: observed %b required at most one bit",
                       cyc, {dot_inp, dash_inp, char_space_inp,
                             word_space_inp, press_err});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name);
        int n;
        vectors++;
        assert (act_q.size() == exp_q.size())
        else begin
            miscompares++;
            $error("FAIL %s count: observed %0d events required %0d",
                   name, act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            assert (act_q[i] === exp_q[i])
            else begin
                miscompares++;
                $error("FAIL %s ev%0d: observed cyc %0d kind %0d required cyc %0d kind %0d",
                       name, i, act_q[i] / 8, act_q[i] % 8,
                       exp_q[i] / 8, exp_q[i] % 8);
            end
        end
    endtask

    // segs alternates press, gap, press ... and ends with a press.
    // Key lengths survive the synchronizer, so rules apply to key_in times.
    task automatic play(input string name);
        int  t;
        int  a;
        int  b;
        int  len;
        bit  pending;
        tick(1);
        act_q.delete();
        exp_q.delete();
        pending = 1'b0;
        b = 0;
        t = cyc;
        for (int i = 0; i < segs.size(); i++) begin
            len = segs[i];
            if (i % 2 == 0) begin
                key_in = 1'b1;
                a = t;
                b = a + len;
                if (len >= MAXP * U) begin
                    exp_q.push_back((a + MAXP * U + LAT + 1) * 8 + K_ERR);
                    pending = 1'b0;
                end else begin
                    exp_q.push_back((b + LAT + 1) * 8 +
                                    ((len / U < DASH) ? K_DOT : K_DASH));
                    pending = 1'b1;
                end
            end else begin
                key_in = 1'b0;
                if (pending && len > CHARG * U)
                    exp_q.push_back((b + CHARG * U + LAT + 1) * 8 + K_CHAR);
                if (pending && len > WORDG * U)
                    exp_q.push_back((b + WORDG * U + LAT + 1) * 8 + K_WORD);
            end
            tick(len);
            t = cyc;
        end
        key_in = 1'b0;
        if (pending) begin
            exp_q.push_back((b + CHARG * U + LAT + 1) * 8 + K_CHAR);
            exp_q.push_back((b + WORDG * U + LAT + 1) * 8 + K_WORD);
        end
        tick(TAIL);
        check(name);
        segs.delete();
    endtask

    initial begin
        int n;
        rst = 1'b0;
        key_in = 1'b0;
        tick(5);
        vectors++;
        assert ({dot_inp, dash_inp, char_space_inp, word_space_inp,
                 press_err} === 5'b0)
        else begin
            miscompares++;
            $error("FAIL reset_outs: observed %b required 00000",
                   {dot_inp, dash_inp, char_space_inp, word_space_inp,
                    press_err});
        end
        rst = 1'b1;
        tick(1);
        act_q.delete();
        exp_q.delete();
        tick(200);
        check("idle200");

`ifndef MORSE_CLASSIFIER_DEBOUNCE_EN
        segs = '{6};          play("dot6");
        segs = '{12};         play("dash12");
        segs = '{8};          play("dash8");
        segs = '{7};          play("dot7");
        segs = '{39};         play("dash39");
        segs = '{40};         play("err40");
        segs = '{6, 8, 12};   play("gap8");
        segs = '{6, 12, 6};   play("gap12");
        segs = '{6, 16, 6};   play("gap16");
        segs = '{6, 28, 6};   play("gap28");
        segs = '{6, 29, 6};   play("gap29");
        segs = '{50};         play("hold50");
        segs = '{40, 1, 6};   play("err_then_dot");
        segs = '{1, 1, 1};    play("short");
`else
        tick(1);
        act_q.delete();
        exp_q.delete();
        repeat (6) begin
            key_in = 1'b1;
            tick(5);
            key_in = 1'b0;
            tick(20);
        end
        tick(TAIL);
        check("glitch5");
        segs = '{12};         play("db_dash12");
`endif

        tick(1);
        act_q.delete();
        exp_q.delete();
        key_in = 1'b1;
        tick(LAT + 10);
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(20);
        key_in = 1'b0;
        tick(TAIL);
        check("rst_mid");
        segs = '{12, 20, 6};  play("post_rst");

        repeat (12) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if (i > 0) segs.push_back($urandom_range(MINL, 34));
                segs.push_back($urandom_range(MINL, 45));
            end
            play("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
